// File: rtl/sliding_window_buffer.sv
// Circular window of the last WINDOW_SIZE accepted samples. Each accepted sample is emitted
// together with the sample it displaces. The displaced value reads as zero until the window
// fills, so downstream running totals stay exact during warm-up.
module sliding_window_buffer #(
   parameter  int unsigned DATA_WIDTH  = 32,
   parameter  int unsigned WINDOW_SIZE = 16,
   localparam int unsigned ADDR_WIDTH  = $clog2(WINDOW_SIZE),
   localparam int unsigned CNT_WIDTH   = $clog2(WINDOW_SIZE + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_flush,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_incoming_data,
   output logic [DATA_WIDTH-1:0] o_outgoing_data,
   output logic [CNT_WIDTH-1:0]  o_count,
   output logic                  o_full
);

   localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(WINDOW_SIZE);

   logic [DATA_WIDTH-1:0] mem_q [WINDOW_SIZE];
   logic                  mem_we_c;
   logic [DATA_WIDTH-1:0] old_c;

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] in_q, in_d;
   logic [DATA_WIDTH-1:0] out_q, out_d;
   logic                  full_q, full_d;

   // Next-state: flush beats a same-cycle sample; an accepted sample reads its slot before overwriting it
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      valid_d  = 1'b0;
      in_d     = in_q;
      out_d    = out_q;
      full_d   = full_q;
      mem_we_c = 1'b0;
      old_c    = mem_q[wr_ptr_q];
      if (i_flush) begin
         wr_ptr_d = '0;
         count_d  = '0;
         full_d   = 1'b0;
      end else if (i_valid) begin
         mem_we_c = 1'b1;
         wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
         count_d  = (count_q == FULL_CNT) ? count_q : count_q + CNT_WIDTH'(1);
         valid_d  = 1'b1;
         in_d     = i_data;
         out_d    = (count_q == FULL_CNT) ? old_c : '0;
         full_d   = (count_d == FULL_CNT);
      end
   end

   // Control and output registers with synchronous active-low reset
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         wr_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         in_q     <= '0;
         out_q    <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         in_q     <= in_d;
         out_q    <= out_d;
         full_q   <= full_d;
      end
   end

   // Sample storage; left unreset because the fill count gates every read that reaches the outputs
   always_ff @(posedge i_clk) begin
      if (i_reset_n && mem_we_c) begin
         mem_q[wr_ptr_q] <= i_data;
      end
   end

   assign o_valid         = valid_q;
   assign o_incoming_data = in_q;
   assign o_outgoing_data = out_q;
   assign o_count         = count_q;
   assign o_full          = full_q;

endmodule

// File: tb/tb_sliding_window_buffer.sv
// Self-checking bench for sliding_window_buffer: a reference window queue produces the expected
// incoming/outgoing pairs, which are queued on drive and popped when o_valid appears.
module tb_sliding_window_buffer;

   localparam int unsigned DW = 32;
   localparam int unsigned WS = 16;
   localparam int unsigned CW = $clog2(WS + 1);

   typedef struct packed {
      logic [DW-1:0] in_data;
      logic [DW-1:0] out_data;
   } exp_t;

   logic          clk = 1'b0;
   logic          i_reset_n = 1'b0;
   logic          i_valid = 1'b0;
   logic [DW-1:0] i_data = '0;
   logic          i_flush = 1'b0;
   logic          o_valid;
   logic [DW-1:0] o_incoming_data;
   logic [DW-1:0] o_outgoing_data;
   logic [CW-1:0] o_count;
   logic          o_full;

   int n_checks = 0;
   int n_errors = 0;

   logic [DW-1:0] win[$];
   exp_t          sb[$];
   logic [DW-1:0] hold_in  = '0;
   logic [DW-1:0] hold_out = '0;

   sliding_window_buffer #(.DATA_WIDTH(DW), .WINDOW_SIZE(WS)) dut (
      .i_clk           (clk),
      .i_reset_n       (i_reset_n),
      .i_valid         (i_valid),
      .i_data          (i_data),
      .i_flush         (i_flush),
      .o_valid         (o_valid),
      .o_incoming_data (o_incoming_data),
      .o_outgoing_data (o_outgoing_data),
      .o_count         (o_count),
      .o_full          (o_full)
   );

   always #5 clk = ~clk;

   // Count one comparison and report it if it mismatches
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle, update the reference model, then check the DUT one edge later
   task automatic step(input logic rst_n, input logic v, input logic f, input logic [DW-1:0] d);
      logic [DW-1:0] outd;
      exp_t          e;
      i_reset_n = rst_n;
      i_valid   = v;
      i_flush   = f;
      i_data    = d;
      if (!rst_n) begin
         win.delete();
         hold_in  = '0;
         hold_out = '0;
      end else if (f) begin
         win.delete();
      end else if (v) begin
         outd = (win.size() == WS) ? win.pop_front() : '0;
         win.push_back(d);
         hold_in  = d;
         hold_out = outd;
         sb.push_back('{in_data: d, out_data: outd});
      end
      @(posedge clk);
      #1;
      check("o_valid", 64'(o_valid), 64'(rst_n && !f && v));
      if (o_valid && sb.size() > 0) begin
         e = sb.pop_front();
         check("sb_incoming", 64'(o_incoming_data), 64'(e.in_data));
         check("sb_outgoing", 64'(o_outgoing_data), 64'(e.out_data));
      end
      check("sb_depth", 64'(sb.size()), 64'd0);
      sb.delete();
      check("hold_incoming", 64'(o_incoming_data), 64'(hold_in));
      check("hold_outgoing", 64'(o_outgoing_data), 64'(hold_out));
      check("o_count", 64'(o_count), 64'(win.size()));
      check("o_full", 64'(o_full), 64'(win.size() == WS));
   endtask

   initial begin
      int r;
      step(1'b0, 1'b0, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, 32'hdead_beef);

      // Warm-up then steady state with pointer wrap: 1..40 back-to-back
      for (int i = 1; i <= 40; i++) step(1'b1, 1'b1, 1'b0, DW'(i));
      check("steady_outgoing_40", 64'(o_outgoing_data), 64'd24);
      check("steady_count", 64'(o_count), 64'(WS));

      // Sparse input after a flush: one sample every third cycle
      step(1'b1, 1'b0, 1'b1, '0);
      for (int i = 1; i <= 20; i++) begin
         step(1'b1, 1'b1, 1'b0, DW'(i + 100));
         step(1'b1, 1'b0, 1'b0, DW'(i));
         step(1'b1, 1'b0, 1'b0, '0);
      end
      check("sparse_outgoing_20", 64'(o_outgoing_data), 64'd104);

      // Flush with a same-cycle sample drops that sample
      step(1'b1, 1'b1, 1'b1, DW'(99));
      check("flush_count", 64'(o_count), 64'd0);
      step(1'b1, 1'b1, 1'b0, DW'(5));
      check("post_flush_out", 64'(o_outgoing_data), 64'd0);
      check("post_flush_count", 64'(o_count), 64'd1);

      // Reset mid-stream must not leak stale window contents
      for (int i = 1; i <= 25; i++) step(1'b1, 1'b1, 1'b0, DW'(i + 200));
      step(1'b0, 1'b1, 1'b1, DW'(7));
      check("reset_out_zero", 64'(o_outgoing_data), 64'd0);
      for (int i = 1; i <= 17; i++) step(1'b1, 1'b1, 1'b0, DW'(i + 300));
      check("reset_evict_first", 64'(o_outgoing_data), 64'd301);

      // Random traffic with occasional flush and reset
      for (int i = 0; i < 10000; i++) begin
         r = int'($urandom_range(0, 999));
         step(r != 0, r > 380, (r > 0) && (r < 12), $urandom());
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
